// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX byte stream among NUM_SRC AXI4-Stream
// byte sources. Each grant is sent as a frame made of one type header byte
// followed by payload bytes up to the source tlast. A packet longer than
// MAX_BURST payload bytes is cut into several frames. Arbitration is
// round-robin and only happens between frames.
// Optional build macro: UART_TX_ARB_CHECKSUM_EN appends an XOR trailer byte
// to every frame.
module uart_tx_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 64,
    parameter logic [NUM_SRC*DATA_WIDTH-1:0] SRC_TYPES = {8'd0, 8'd5, 8'd2, 8'd3},
    localparam int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    output logic [NUM_SRC-1:0]            s_tready,
    input  logic [NUM_SRC-1:0]            s_tlast,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic [SEL_W-1:0]              grant_id,
    output logic                          busy,
    output logic [15:0]                   frag_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
`ifdef UART_TX_ARB_CHECKSUM_EN
        S_PAYLOAD,
        S_TRAILER
`else
        S_PAYLOAD
`endif
    } state_t;

    state_t                  state_reg;
    logic [SEL_W-1:0]        grant_reg;
    logic [SEL_W-1:0]        rr_ptr_reg;
    logic [7:0]              byte_cnt_reg;
    logic [15:0]             frag_reg;
`ifdef UART_TX_ARB_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   xor_reg;
`endif

    logic                    pick_found;
    logic [SEL_W-1:0]        pick_idx;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_valid;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   header_byte;
    logic                    burst_hit;
    logic                    end_frame;
    logic                    pay_xfer;

    // Round-robin scan starting just after the last granted source.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_reg;
        for (int k = 1; k <= NUM_SRC; k++) begin
            int idx;
            idx = (int'(rr_ptr_reg) + k) % NUM_SRC;
            if (!pick_found && s_tvalid[idx[SEL_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = idx[SEL_W-1:0];
            end
        end
    end

    assign sel_data    = s_tdata[int'(grant_reg)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_valid   = s_tvalid[grant_reg];
    assign sel_last    = s_tlast[grant_reg];
    assign header_byte = SRC_TYPES[int'(grant_reg)*DATA_WIDTH +: DATA_WIDTH];
    assign burst_hit   = (byte_cnt_reg == 8'(MAX_BURST - 1));
    assign end_frame   = sel_last | burst_hit;
    assign pay_xfer    = (state_reg == S_PAYLOAD) && sel_valid && m_tready;

    // Ready goes only to the granted source, and only while payload is flowing.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
            assign s_tready[gi] = (state_reg == S_PAYLOAD) &&
                                  (grant_reg == SEL_W'(gi)) && m_tready;
        end
    endgenerate

    // Output mux: header, payload pass-through or trailer, selected by state.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        case (state_reg)
            S_HEADER: begin
                m_tdata  = header_byte;
                m_tvalid = 1'b1;
            end
            S_PAYLOAD: begin
                m_tdata  = sel_data;
                m_tvalid = sel_valid;
`ifdef UART_TX_ARB_CHECKSUM_EN
                m_tlast  = 1'b0;
`else
                m_tlast  = end_frame;
`endif
            end
`ifdef UART_TX_ARB_CHECKSUM_EN
            S_TRAILER: begin
                m_tdata  = xor_reg;
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy       = (state_reg != S_IDLE);
    assign grant_id   = grant_reg;
    assign frag_count = frag_reg;

    // Frame sequencer: grant, header, payload (with burst cut), optional trailer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            grant_reg    <= '0;
            rr_ptr_reg   <= SEL_W'(NUM_SRC - 1);
            byte_cnt_reg <= '0;
            frag_reg     <= '0;
`ifdef UART_TX_ARB_CHECKSUM_EN
            xor_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_reg  <= pick_idx;
                        rr_ptr_reg <= pick_idx;
                        state_reg  <= S_HEADER;
`ifdef UART_TX_ARB_CHECKSUM_EN
                        xor_reg    <= '0;
`endif
                    end
                end
                S_HEADER: begin
                    if (m_tready) begin
                        byte_cnt_reg <= '0;
                        state_reg    <= S_PAYLOAD;
`ifdef UART_TX_ARB_CHECKSUM_EN
                        xor_reg      <= xor_reg ^ header_byte;
`endif
                    end
                end
                S_PAYLOAD: begin
                    if (pay_xfer) begin
                        byte_cnt_reg <= byte_cnt_reg + 8'd1;
`ifdef UART_TX_ARB_CHECKSUM_EN
                        xor_reg      <= xor_reg ^ sel_data;
`endif
                        if (end_frame) begin
                            // Count cut was forced, not a natural packet end.
                            if (!sel_last && frag_reg != 16'hFFFF) begin
                                frag_reg <= frag_reg + 16'd1;
                            end
`ifdef UART_TX_ARB_CHECKSUM_EN
                            state_reg <= S_TRAILER;
`else
                            state_reg <= S_IDLE;
`endif
                        end
                    end
                end
`ifdef UART_TX_ARB_CHECKSUM_EN
                S_TRAILER: begin
                    if (m_tready) begin
                        state_reg <= S_IDLE;
                    end
                end
`endif
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (MAX_BURST overridden to 4 so that
// fragmentation is reachable with short packets). Honours
// UART_TX_ARB_CHECKSUM_EN when expecting trailer bytes.
module tb_uart_tx_arbiter;

    localparam int NUM_SRC = 4;
`ifdef UART_TX_ARB_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic [NUM_SRC*8-1:0]  s_tdata;
    logic [NUM_SRC-1:0]    s_tvalid;
    logic [NUM_SRC-1:0]    s_tready;
    logic [NUM_SRC-1:0]    s_tlast;
    logic [7:0]            m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;
    logic [1:0]            grant_id;
    logic                  busy;
    logic [15:0]           frag_count;

    uart_tx_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .grant_id(grant_id), .busy(busy), .frag_count(frag_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int viol  = 0;
    bit bp_mode = 1'b0;

    logic [8:0] src_mem [NUM_SRC][16];
    int         src_rd  [NUM_SRC];
    int         src_wr  [NUM_SRC];
    logic [8:0] out_q[$];
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic load_src(input int s, input logic [63:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            src_mem[s][src_wr[s]] = {(k == n - 1), b[8*(n-1-k) +: 8]};
            src_wr[s]++;
        end
    endtask

    task automatic exp_frame(input logic [7:0] hdr, input logic [63:0] b, input int n);
        logic [7:0] x;
        logic [7:0] d;
        x = hdr;
        exp_q.push_back({1'b0, hdr});
        for (int k = 0; k < n; k++) begin
            d = b[8*(n-1-k) +: 8];
            x = x ^ d;
            exp_q.push_back({(k == n - 1) && !CS, d});
        end
        if (CS) exp_q.push_back({1'b1, x});
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                s_tvalid[i]       = 1'b1;
                s_tlast[i]        = src_mem[i][src_rd[i]][8];
                s_tdata[i*8 +: 8] = src_mem[i][src_rd[i]][7:0];
            end else begin
                s_tvalid[i]       = 1'b0;
                s_tlast[i]        = 1'b0;
                s_tdata[i*8 +: 8] = 8'h00;
            end
        end
        m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // One clock: drive, sample mid-cycle, then move just past the edge.
    task automatic step();
        drive_inputs();
        @(negedge clk);
        if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
        for (int i = 0; i < NUM_SRC; i++) begin
            if (s_tvalid[i] && s_tready[i]) src_rd[i]++;
            if (s_tready[i] && !(busy && int'(grant_id) == i)) viol++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input string tag, input int n, input int budget, output int cyc);
        cyc = 0;
        while (out_q.size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        if (out_q.size() < n) check({tag, "_timeout"}, out_q.size(), n);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_SRC; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        out_q.delete();
        exp_q.delete();
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
    endtask

    task automatic do_reset();
        clear_all();
        rst_n    = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_len"}, out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int k = 0; k < n; k++)
            check($sformatf("%s_b%0d", tag, k), {23'd0, out_q[k]}, {23'd0, exp_q[k]});
    endtask

    initial begin
        int cyc;
        rst_n    = 1'b0;
        m_tready = 1'b0;
        clear_all();
        do_reset();

        // Reset state
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_frag_count", frag_count, 0);

        // Test 1: single request from src2
        load_src(2, 64'hAABB, 2);
        exp_frame(8'h05, 64'hAABB, 2);
        run_until("t1", exp_q.size(), 50, cyc);
        repeat (4) step();
        compare_stream("t1");
        check("t1_grant_id", grant_id, 2);
        check("t1_busy_after", busy, 0);
        check("t1_src_drained", src_rd[2], src_wr[2]);

        // Test 4: same traffic under random backpressure
        clear_all();
        bp_mode = 1'b1;
        load_src(2, 64'hAABB, 2);
        exp_frame(8'h05, 64'hAABB, 2);
        run_until("t4", exp_q.size(), 300, cyc);
        repeat (6) step();
        bp_mode = 1'b0;
        compare_stream("t4");
        check("t4_src_drained", src_rd[2], src_wr[2]);

        // Test 2: all sources request at once after reset
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) load_src(i, 64'(8'h10 + i), 1);
        exp_frame(8'h03, 64'h10, 1);
        exp_frame(8'h02, 64'h11, 1);
        exp_frame(8'h05, 64'h12, 1);
        exp_frame(8'h00, 64'h13, 1);
        run_until("t2", exp_q.size(), 100, cyc);
        check("t2_cycles", cyc, CS ? 16 : 12);
        repeat (4) step();
        compare_stream("t2");
        for (int i = 0; i < NUM_SRC; i++)
            check($sformatf("t2_src%0d_served", i), src_rd[i], 1);

        // Test 3: 6-byte packet from src1 cut at MAX_BURST=4
        do_reset();
        load_src(1, 64'h010203040506, 6);
        exp_frame(8'h02, 64'h01020304, 4);
        exp_frame(8'h02, 64'h0506, 2);
        run_until("t3", exp_q.size(), 100, cyc);
        repeat (4) step();
        compare_stream("t3");
        check("t3_frag_count", frag_count, 1);

        // Test 5: reset after header + one payload byte of src0
        clear_all();
        load_src(0, 64'hA0A1A2, 3);
        load_src(1, 64'hB0, 1);
        run_until("t5a", 2, 50, cyc);
        check("t5_pre_busy", busy, 1);
        rst_n    = 1'b0;
        s_tvalid = '0;
        @(posedge clk);
        #1;
        check("t5_rst_m_tvalid", m_tvalid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_frag_count", frag_count, 0);
        rst_n = 1'b1;
        clear_all();
        load_src(0, 64'hC0C1, 2);
        load_src(1, 64'hD0, 1);
        exp_frame(8'h03, 64'hC0C1, 2);
        exp_frame(8'h02, 64'hD0, 1);
        run_until("t5", exp_q.size(), 100, cyc);
        repeat (4) step();
        compare_stream("t5");
        check("t5_grant_id", grant_id, 1);

        check("s_tready_to_idle_src", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
